ps2_host_tx: RTL and testbench
==============================

# ps2_host_tx

Host-to-device PS/2 transmitter for the keyboard port. It sends command bytes to the keyboard, such as 0xED set-LEDs, 0xFF reset and 0xF3 typematic, using the open-collector outputs that drive the ps2kCk and ps2kDQ pins. It complements the existing PS/2 receive path. It implements the inhibit, request-to-send, bit-shift and acknowledge phases of the PS/2 host transmit protocol, with timeouts so that a missing or stuck keyboard can never hang the port.

## Interface
Parameters:
- INHIBIT_CYC, default 2400: cycles the host holds clock low before request-to-send (100 µs at 24 MHz).
- START_TO, default 360000: maximum cycles from clock release to the first device falling edge (15 ms).
- XFER_TO, default 48000: maximum cycles from the first falling edge until the line returns idle (2 ms).
- FILT, default 8: cycles a synchronized input must be stable before its new level is accepted.

Ports (clock and reset first):
- clk_sys, in, 1: system clock.
- res_n, in, 1: asynchronous, active-low reset.
- tx_data, in, 8: byte to send; captured on accept.
- tx_valid, in, 1: request to send.
- tx_ready, out, 1: block idle; a byte is accepted when tx_valid and tx_ready are both high.
- tx_done, out, 1: one-cycle pulse; the byte was acknowledged by the device.
- tx_error, out, 1: one-cycle pulse; timeout or missing ack.
- busy, out, 1: transfer in progress, equal to ~tx_ready.
- ps2_clk_in, in, 1: raw pin level, asynchronous.
- ps2_dat_in, in, 1: raw pin level, asynchronous.
- ps2_clk_out, out, 1: 0 drives the pin low; 1 releases it (high-Z).
- ps2_dat_out, out, 1: 0 drives the pin low; 1 releases it (high-Z).

## Operation
Input conditioning:
- Each input passes through a 2-flop synchronizer, then a FILT-cycle stability filter.
- A device falling edge (clk_fall) is a filtered clock transition from 1 to 0.

Frame:
- Frame = start(0), d0..d7 (LSB first), odd parity, stop(1), then the device ack.
- Parity = ~^tx_data.

State machine:
- IDLE: clock and data released, tx_ready=1. On accept, latch tx_data, load the counter with INHIBIT_CYC and go to INHIBIT.
- INHIBIT: ps2_clk_out=0 for exactly INHIBIT_CYC cycles. In the last cycle, ps2_dat_out=0. Then go to RTS.
- RTS: ps2_dat_out=0, ps2_clk_out released. Load the counter with START_TO.
  - On clk_fall: go to SHIFT with bit index 0, reload the counter with XFER_TO, and drive d0 onto data.
  - If the counter expires first: go to ERROR.
- SHIFT: on each clk_fall, the index advances and data is driven as follows:
  - Falling edges 1..8 drive d0..d7.
  - Falling edge 9 drives parity.
  - Falling edge 10 releases data (stop bit).
  - On falling edge 11, sample filtered data: 0 goes to WAIT_IDLE; 1 goes to ERROR (no ack).
- WAIT_IDLE: wait until filtered clock and data are both 1, then go to DONE.
- DONE: pulse tx_done for one cycle, then go to IDLE.
- ERROR: release both lines, pulse tx_error for one cycle, then go to IDLE.
- The XFER_TO counter runs continuously through SHIFT and WAIT_IDLE. Expiry in either state goes to ERROR.
- Data changes only in the cycle after clk_fall is detected, so it is always stable before the device's rising-edge sample.

Boundary conditions:
- tx_valid while busy: ignored; it is not queued, and tx_data changes have no effect.
- Device already transmitting at accept: the host inhibit overrides it. The byte is lost on the receive side, which is the receiver's concern.
- tx_done and tx_error are never asserted in the same cycle.
- Asynchronous reset at any point: both lines are released immediately, the state returns to IDLE, and no pulse is generated.

## Timing
Reset values:
- ps2_clk_out=1, ps2_dat_out=1.
- tx_ready=1, busy=0, tx_done=0, tx_error=0.
- All counters 0; state IDLE.

Cycle-level timing:
- Accept at cycle N: ps2_clk_out=0 from cycle N+1 to N+INHIBIT_CYC inclusive. ps2_dat_out=0 from cycle N+INHIBIT_CYC. The clock is released at N+INHIBIT_CYC+1.
- Output latency from a pin edge to a data change is 2 (synchronizer) + FILT + 1 cycles.
- tx_done and tx_error are each one cycle wide. tx_ready returns to 1 in the cycle after the pulse.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
The bench uses a behavioural keyboard model and INHIBIT_CYC=20, START_TO=2000, XFER_TO=4000, FILT=4.
- Send 0xED, with the model clocking at a 40-cycle period and acking:
  - The model decodes start 0, bits 1,0,1,1,0,1,1,1, parity 1 and stop 1.
  - ps2_clk_out is low for exactly 20 cycles.
  - tx_done pulses once after the model releases the lines.
- Parity sweep with 0x00, 0x01 and 0xFF: the model sees parity 1, 0 and 1 respectively, and every transfer ends in tx_done.
- Model never clocks after clock release: tx_error pulses 2000 cycles (±filter latency) after RTS entry, and both outputs return to 1.
- Model omits the ack (data high on the 11th falling edge): tx_error fires, no tx_done, and tx_ready returns to 1.
- Reset timing:
  - Assert res_n=0 after the model's 5th falling edge: ps2_clk_out and ps2_dat_out go to 1 asynchronously, with no pulse.
  - After release, a new 0xF3 transfer completes with tx_done.
- tx_valid held high with tx_data changing during a transfer: only the first byte is sent, and a second accept occurs only after tx_done.

Source files
------------

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: inhibit, request-to-send, bit shift on device clock
// falls and ack check, with timeouts so an absent or stuck keyboard cannot hang the port.
module ps2_host_tx #(
    parameter int unsigned INHIBIT_CYC = 2400,
    parameter int unsigned START_TO    = 360000,
    parameter int unsigned XFER_TO     = 48000,
    parameter int unsigned FILT        = 8
) (
    input  logic       clk_sys,
    input  logic       res_n,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx_done,
    output logic       tx_error,
    output logic       busy,
    input  logic       ps2_clk_in,
    input  logic       ps2_dat_in,
    output logic       ps2_clk_out,
    output logic       ps2_dat_out
);

    localparam int unsigned MaxTx  = (START_TO > XFER_TO) ? START_TO : XFER_TO;
    localparam int unsigned CntMax = (MaxTx > INHIBIT_CYC) ? MaxTx : INHIBIT_CYC;
    localparam int unsigned CntW   = $clog2(CntMax + 1);
    localparam int unsigned FiltW  = (FILT > 1) ? $clog2(FILT) : 1;

    typedef enum logic [2:0] {
        StIdle, StInhibit, StRts, StShift, StWaitIdle, StDone, StError
    } state_e;

    // Bit 0 is the clock pin, bit 1 the data pin.
    logic [1:0]       pin_raw;
    logic [1:0]       sync1_q, sync2_q, filt_q, filt_prev_q;
    logic [FiltW-1:0] stab_cnt_q [2];
    logic             clk_fall, clk_filt, dat_filt;

    assign pin_raw = {ps2_dat_in, ps2_clk_in};

    always_ff @(posedge clk_sys or negedge res_n) begin
        if (!res_n) begin
            sync1_q       <= '1;
            sync2_q       <= '1;
            filt_q        <= '1;
            filt_prev_q   <= '1;
            stab_cnt_q[0] <= '0;
            stab_cnt_q[1] <= '0;
        end else begin
            sync1_q     <= pin_raw;
            sync2_q     <= sync1_q;
            filt_prev_q <= filt_q;
            for (int i = 0; i < 2; i++) begin
                if (sync2_q[i] == filt_q[i]) begin
                    stab_cnt_q[i] <= '0;
                end else if (stab_cnt_q[i] == FiltW'(FILT - 1)) begin
                    filt_q[i]     <= sync2_q[i];
                    stab_cnt_q[i] <= '0;
                end else begin
                    stab_cnt_q[i] <= stab_cnt_q[i] + 1'b1;
                end
            end
        end
    end

    assign clk_filt = filt_q[0];
    assign dat_filt = filt_q[1];
    assign clk_fall = filt_prev_q[0] & ~filt_q[0];

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [3:0]      fall_q, fall_d;
    logic [7:0]      data_q, data_d;
    logic            clk_out_q, clk_out_d, dat_out_q, dat_out_d;
    logic            ready_q, ready_d, busy_q, done_q, done_d, error_q, error_d;

    always_ff @(posedge clk_sys or negedge res_n) begin
        if (!res_n) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            fall_q    <= '0;
            data_q    <= '0;
            clk_out_q <= 1'b1;
            dat_out_q <= 1'b1;
            ready_q   <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            error_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            fall_q    <= fall_d;
            data_q    <= data_d;
            clk_out_q <= clk_out_d;
            dat_out_q <= dat_out_d;
            ready_q   <= ready_d;
            busy_q    <= ~ready_d;
            done_q    <= done_d;
            error_q   <= error_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        fall_d  = fall_q;
        data_d  = data_q;
        unique case (state_q)
            StIdle: begin
                if (tx_valid && ready_q) begin
                    data_d  = tx_data;
                    cnt_d   = CntW'(INHIBIT_CYC);
                    state_d = StInhibit;
                end
            end
            StInhibit: begin
                if (cnt_q <= CntW'(1)) begin
                    cnt_d   = CntW'(START_TO);
                    state_d = StRts;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StRts: begin
                if (clk_fall) begin
                    fall_d  = 4'd1;
                    cnt_d   = CntW'(XFER_TO);
                    state_d = StShift;
                end else if (cnt_q == '0) begin
                    state_d = StError;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StShift: begin
                if (cnt_q == '0) begin
                    state_d = StError;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                    if (clk_fall) begin
                        // Eleventh fall: device should be holding data low as its ack.
                        if (fall_q == 4'd10) begin
                            state_d = dat_filt ? StError : StWaitIdle;
                        end else begin
                            fall_d = fall_q + 4'd1;
                        end
                    end
                end
            end
            StWaitIdle: begin
                if (cnt_q == '0) begin
                    state_d = StError;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                    if (clk_filt && dat_filt) begin
                        state_d = StDone;
                    end
                end
            end
            StDone, StError: begin
                cnt_d   = '0;
                fall_d  = '0;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // Decoded from next state so every output comes straight from a flop.
    always_comb begin
        clk_out_d = 1'b1;
        dat_out_d = 1'b1;
        ready_d   = 1'b0;
        done_d    = 1'b0;
        error_d   = 1'b0;
        unique case (state_d)
            StIdle:    ready_d = 1'b1;
            StInhibit: begin
                clk_out_d = 1'b0;
                dat_out_d = (cnt_d > CntW'(1));
            end
            StRts:     dat_out_d = 1'b0;
            StShift: begin
                if (fall_d >= 4'd1 && fall_d <= 4'd8) begin
                    dat_out_d = data_d[3'(fall_d - 4'd1)];
                end else if (fall_d == 4'd9) begin
                    dat_out_d = ~^data_d;
                end
            end
            StDone:    done_d  = 1'b1;
            StError:   error_d = 1'b1;
            default:   ;
        endcase
    end

    assign ps2_clk_out = clk_out_q;
    assign ps2_dat_out = dat_out_q;
    assign tx_ready    = ready_q;
    assign busy        = busy_q;
    assign tx_done     = done_q;
    assign tx_error    = error_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx with a behavioural open-collector keyboard model.
module tb_ps2_host_tx;

    logic       clk_sys = 1'b0;
    logic       res_n;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready, tx_done, tx_error, busy;
    logic       ps2_clk_out, ps2_dat_out;
    logic       dev_clk, dev_dat;
    wire        ps2_clk_in = ps2_clk_out & dev_clk;
    wire        ps2_dat_in = ps2_dat_out & dev_dat;

    ps2_host_tx #(
        .INHIBIT_CYC (20),
        .START_TO    (2000),
        .XFER_TO     (4000),
        .FILT        (4)
    ) dut (
        .clk_sys     (clk_sys),
        .res_n       (res_n),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .tx_done     (tx_done),
        .tx_error    (tx_error),
        .busy        (busy),
        .ps2_clk_in  (ps2_clk_in),
        .ps2_dat_in  (ps2_dat_in),
        .ps2_clk_out (ps2_clk_out),
        .ps2_dat_out (ps2_dat_out)
    );

    always #5 clk_sys = ~clk_sys;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0, done_cnt = 0, err_cnt = 0, both_cnt = 0, accept_cnt = 0;
    int low_run = 0, last_low = 0;

    always @(negedge clk_sys) begin
        cyc <= cyc + 1;
        if (tx_done)             done_cnt <= done_cnt + 1;
        if (tx_error)            err_cnt  <= err_cnt + 1;
        if (tx_done && tx_error) both_cnt <= both_cnt + 1;
        if (!ps2_clk_out) begin
            low_run <= low_run + 1;
        end else if (low_run != 0) begin
            last_low <= low_run;
            low_run  <= 0;
        end
    end

    always @(posedge clk_sys) begin
        if (res_n && tx_valid && tx_ready) accept_cnt <= accept_cnt + 1;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running, required to finish");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk_sys);
        #1;
    endtask

    task automatic start_tx(input logic [7:0] d);
        tick();
        tx_data  = d;
        tx_valid = 1'b1;
        tick();
        tx_valid = 1'b0;
    endtask

    // Wait until a done or error pulse has been counted beyond base, or budget runs out.
    task automatic wait_any(input int base, input int budget);
        for (int t = 0; t < budget && (done_cnt + err_cnt) == base; t++) tick();
    endtask

    // Keyboard model: waits for request-to-send, reads start bit, clocks ten bits at a
    // 40-cycle period sampling on rising edges, then the ack clock. stop_at aborts
    // right after that falling edge.
    task automatic kbd_send(input bit ack, input int stop_at, output logic [10:0] frame,
                            output bit ok);
        ok    = 1'b0;
        frame = '0;
        for (int t = 0; t < 3000 && !ok; t++) begin
            tick();
            if (ps2_clk_out && !ps2_dat_out) ok = 1'b1;
        end
        if (!ok) return;
        repeat (10) tick();
        frame[0] = ps2_dat_in;
        for (int k = 1; k <= 10; k++) begin
            dev_clk = 1'b0;
            if (k == stop_at) return;
            repeat (20) tick();
            dev_clk  = 1'b1;
            frame[k] = ps2_dat_in;
            repeat (20) tick();
        end
        if (ack) dev_dat = 1'b0;
        repeat (10) tick();
        dev_clk = 1'b0;
        repeat (20) tick();
        dev_clk = 1'b1;
        repeat (10) tick();
        dev_dat = 1'b1;
    endtask

    logic [7:0]  sweep_dat [3] = '{8'h00, 8'h01, 8'hFF};
    logic [10:0] sweep_frm [3] = '{11'h600, 11'h402, 11'h7FE};

    initial begin
        logic [10:0] frame;
        bit          ok;
        int          d0, e0, a0, t_rts;

        res_n    = 1'b0;
        tx_data  = 8'h00;
        tx_valid = 1'b0;
        dev_clk  = 1'b1;
        dev_dat  = 1'b1;
        repeat (3) tick();
        res_n = 1'b1;
        repeat (2) tick();

        check_eq("rst_clk_out", ps2_clk_out, 1);
        check_eq("rst_dat_out", ps2_dat_out, 1);
        check_eq("rst_ready", tx_ready, 1);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_done", tx_done, 0);
        check_eq("rst_error", tx_error, 0);

        // 0xED with ack
        d0 = done_cnt; e0 = err_cnt;
        start_tx(8'hED);
        check_eq("ed_busy", busy, 1);
        kbd_send(1'b1, 0, frame, ok);
        check_eq("ed_rts_seen", ok, 1);
        check_eq("ed_frame", frame, 11'h7DA);
        check_eq("ed_inhibit_len", last_low, 20);
        check_eq("ed_no_early_done", done_cnt - d0, 0);
        wait_any(d0 + e0, 200);
        repeat (5) tick();
        check_eq("ed_done", done_cnt - d0, 1);
        check_eq("ed_no_error", err_cnt - e0, 0);
        check_eq("ed_ready_after", tx_ready, 1);

        // parity sweep
        for (int i = 0; i < 3; i++) begin
            d0 = done_cnt; e0 = err_cnt;
            start_tx(sweep_dat[i]);
            kbd_send(1'b1, 0, frame, ok);
            check_eq($sformatf("sweep_frame_%0h", sweep_dat[i]), frame, sweep_frm[i]);
            wait_any(d0 + e0, 200);
            check_eq($sformatf("sweep_done_%0h", sweep_dat[i]), done_cnt - d0, 1);
            check_eq($sformatf("sweep_err_%0h", sweep_dat[i]), err_cnt - e0, 0);
        end

        // keyboard never clocks: start timeout
        repeat (20) tick();
        d0 = done_cnt; e0 = err_cnt;
        start_tx(8'h3C);
        ok = 1'b0;
        t_rts = 0;
        for (int t = 0; t < 200 && !ok; t++) begin
            tick();
            if (ps2_clk_out && !ps2_dat_out) begin
                ok    = 1'b1;
                t_rts = cyc;
            end
        end
        check_eq("to_rts_seen", ok, 1);
        wait_any(d0 + e0, 2500);
        check_eq("to_delay_ok", ((cyc - t_rts) >= 1990) && ((cyc - t_rts) <= 2012), 1);
        check_eq("to_error", err_cnt - e0, 1);
        check_eq("to_no_done", done_cnt - d0, 0);
        tick();
        check_eq("to_clk_out", ps2_clk_out, 1);
        check_eq("to_dat_out", ps2_dat_out, 1);
        check_eq("to_ready", tx_ready, 1);

        // missing ack
        repeat (20) tick();
        d0 = done_cnt; e0 = err_cnt;
        start_tx(8'hF4);
        kbd_send(1'b0, 0, frame, ok);
        wait_any(d0 + e0, 200);
        repeat (3) tick();
        check_eq("noack_error", err_cnt - e0, 1);
        check_eq("noack_no_done", done_cnt - d0, 0);
        check_eq("noack_ready", tx_ready, 1);

        // asynchronous reset mid-frame
        repeat (20) tick();
        start_tx(8'hAA);
        kbd_send(1'b1, 5, frame, ok);
        repeat (12) tick();
        check_eq("rstmid_dat_d4", ps2_dat_out, 0);
        d0 = done_cnt; e0 = err_cnt;
        #2;
        res_n = 1'b0;
        #1;
        check_eq("rstmid_clk_out", ps2_clk_out, 1);
        check_eq("rstmid_dat_out", ps2_dat_out, 1);
        check_eq("rstmid_ready", tx_ready, 1);
        dev_clk = 1'b1;
        repeat (5) tick();
        res_n = 1'b1;
        repeat (20) tick();
        check_eq("rstmid_no_done", done_cnt - d0, 0);
        check_eq("rstmid_no_err", err_cnt - e0, 0);

        d0 = done_cnt; e0 = err_cnt;
        start_tx(8'hF3);
        kbd_send(1'b1, 0, frame, ok);
        check_eq("f3_frame", frame, 11'h7E6);
        wait_any(d0 + e0, 200);
        check_eq("f3_done", done_cnt - d0, 1);

        // tx_valid held with tx_data changing while busy
        repeat (20) tick();
        d0 = done_cnt; e0 = err_cnt; a0 = accept_cnt;
        tx_data  = 8'h5A;
        tx_valid = 1'b1;
        tick();
        tick();
        tx_data = 8'hC3;
        kbd_send(1'b1, 0, frame, ok);
        check_eq("hold_frame1", frame, 11'h6B4);
        wait_any(d0 + e0, 200);
        check_eq("hold_done1", done_cnt - d0, 1);
        check_eq("hold_one_accept", accept_cnt - a0, 1);
        tick();
        tick();
        tx_valid = 1'b0;
        check_eq("hold_second_accept", accept_cnt - a0, 2);
        check_eq("hold_busy_again", busy, 1);
        d0 = done_cnt; e0 = err_cnt;
        kbd_send(1'b1, 0, frame, ok);
        check_eq("hold_frame2", frame, 11'h786);
        wait_any(d0 + e0, 200);
        check_eq("hold_done2", done_cnt - d0, 1);

        repeat (5) tick();
        check_eq("never_done_and_error", both_cnt, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
